// File: rtl/antifurto_pkg.sv
// -----------------------------------------------------------------------------
// antifurto_pkg
// Shared types and constants for the multi-zone anti-theft controller:
//   - state_t     : controller FSM states
//   - param_sel_t : time-parameter select codes (also used for the interval output)
//   - STATUS_*    : status output codes
//   - T_*_DEFAULT : default time parameters, in seconds
//   - status_of() : maps an FSM state to its status code
// -----------------------------------------------------------------------------
package antifurto_pkg;

  typedef enum logic [2:0] {
    ARMED,
    TRIGGERED,
    ALARM,
    DISARMED,
    WAIT_CLOSE,
    ARM_DELAY
  } state_t;

  typedef enum logic [1:0] {
    SEL_ARM    = 2'b00,
    SEL_DRIVER = 2'b01,
    SEL_PASS   = 2'b10,
    SEL_ALARM  = 2'b11
  } param_sel_t;

  localparam logic [1:0] STATUS_ARMED     = 2'b00;
  localparam logic [1:0] STATUS_TRIGGERED = 2'b01;
  localparam logic [1:0] STATUS_ALARM     = 2'b10;
  localparam logic [1:0] STATUS_DISARMED  = 2'b11;

  localparam int T_ARM_DEFAULT    = 6;
  localparam int T_DRIVER_DEFAULT = 8;
  localparam int T_PASS_DEFAULT   = 15;
  localparam int T_ALARM_DEFAULT  = 10;

  // WAIT_CLOSE and ARM_DELAY are internal sub-steps of "disarmed" as far as
  // the outside world is concerned.
  function automatic logic [1:0] status_of(input state_t s);
    case (s)
      ARMED:     return STATUS_ARMED;
      TRIGGERED: return STATUS_TRIGGERED;
      ALARM:     return STATUS_ALARM;
      default:   return STATUS_DISARMED;
    endcase
  endfunction

endpackage

// File: rtl/antifurto_timer.sv
// -----------------------------------------------------------------------------
// antifurto_timer
// Down-counter in seconds for the anti-theft controller.
//   clock, reset      : system clock, asynchronous active-low reset
//   load, load_value  : load the counter (takes priority over counting)
//   one_hz_enable     : single-cycle 1 Hz tick; decrements while counter > 0
//   counter           : remaining seconds
//   expired           : counter has reached zero
// Load values are never zero (the parameter bank stores 0 as 1), so expired
// cannot assert on the cycle right after a load.
// -----------------------------------------------------------------------------
module antifurto_timer #(
  parameter int TW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  input  logic          one_hz_enable,
  output logic [TW-1:0] counter,
  output logic          expired
);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter <= '0;
    end else if (load) begin
      counter <= load_value;
    end else if (one_hz_enable && (counter != '0)) begin
      counter <= counter - TW'(1);
    end
  end

  assign expired = (counter == '0);

endmodule

// File: rtl/fsm_antifurto_multizone.sv
// -----------------------------------------------------------------------------
// fsm_antifurto_multizone
// Anti-theft controller for NUM_DOORS doors (door 0 = driver) with a
// programmable time-parameter bank, countdown timer and fuel-pump interlock.
//   clock, reset       : system clock, asynchronous active-low reset
//   one_hz_enable      : single-cycle 1 Hz tick
//   ignition           : ignition on (highest priority: disarms)
//   door               : 1 = door open
//   reprogram          : pulse; store time_value into time_param_sel parameter
//   time_param_sel     : 00 ARM, 01 DRIVER, 10 PASS, 11 ALARM
//   time_value         : new parameter value (0 is stored as 1)
//   hidden_sw, brake   : fuel-pump enable conditions together with ignition
//   status             : 00 armed, 01 triggered, 10 alarm, 11 disarmed
//   interval           : parameter currently being timed
//   enable_siren       : siren on
//   fuel_pump_power    : fuel pump enabled
//   timer_value        : remaining seconds
//   alarm_source       : doors that triggered / were opened while alarmed
// -----------------------------------------------------------------------------
module fsm_antifurto_multizone
  import antifurto_pkg::*;
#(
  parameter int NUM_DOORS    = 4,
  parameter int TW           = 4,
  parameter int T_ARM_DEF    = T_ARM_DEFAULT,
  parameter int T_DRIVER_DEF = T_DRIVER_DEFAULT,
  parameter int T_PASS_DEF   = T_PASS_DEFAULT,
  parameter int T_ALARM_DEF  = T_ALARM_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 one_hz_enable,
  input  logic                 ignition,
  input  logic [NUM_DOORS-1:0] door,
  input  logic                 reprogram,
  input  logic [1:0]           time_param_sel,
  input  logic [TW-1:0]        time_value,
  input  logic                 hidden_sw,
  input  logic                 brake,
  output logic [1:0]           status,
  output logic [1:0]           interval,
  output logic                 enable_siren,
  output logic                 fuel_pump_power,
  output logic [TW-1:0]        timer_value,
  output logic [NUM_DOORS-1:0] alarm_source
);

  state_t        state;
  param_sel_t    interval_q;
  logic [TW-1:0] params [4];

  logic          door_any;
  logic          load;
  param_sel_t    load_sel;
  logic [TW-1:0] load_value;
  logic          expired;

  assign door_any = |door;

  // ---------------------------------------------------------------------------
  // Time-parameter bank
  // ---------------------------------------------------------------------------
  // NOTE: this small register bank is reset because its defaults are part of
  // the controller's behaviour; a plain storage RAM would not be reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      params[SEL_ARM]    <= TW'(T_ARM_DEF);
      params[SEL_DRIVER] <= TW'(T_DRIVER_DEF);
      params[SEL_PASS]   <= TW'(T_PASS_DEF);
      params[SEL_ALARM]  <= TW'(T_ALARM_DEF);
    end else if (reprogram) begin
      // A zero delay would make the timer look expired right after loading.
      params[time_param_sel] <= (time_value == '0) ? TW'(1) : time_value;
    end
  end

  // ---------------------------------------------------------------------------
  // Timer load request: asserted on the same edge the FSM enters a timed
  // state, so the counter holds the fresh value together with the new state.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    load     = 1'b0;
    load_sel = SEL_ARM;
    if (!ignition && !reprogram) begin
      case (state)
        ARMED: begin
          if (door_any) begin
            load     = 1'b1;
            load_sel = door[0] ? SEL_DRIVER : SEL_PASS;  // driver door wins
          end
        end
        TRIGGERED: begin
          if (expired) begin
            load     = 1'b1;
            load_sel = SEL_ALARM;
          end
        end
        ALARM: begin
          // Any open door keeps the siren hold topped up.
          if (door_any) begin
            load     = 1'b1;
            load_sel = SEL_ALARM;
          end
        end
        WAIT_CLOSE: begin
          if (!door_any) begin
            load     = 1'b1;
            load_sel = SEL_ARM;
          end
        end
        default: ;
      endcase
    end
  end

  assign load_value = params[load_sel];

  antifurto_timer #(
    .TW (TW)
  ) u_timer (
    .clock         (clock),
    .reset         (reset),
    .load          (load),
    .load_value    (load_value),
    .one_hz_enable (one_hz_enable),
    .counter       (timer_value),
    .expired       (expired)
  );

  // ---------------------------------------------------------------------------
  // Controller FSM with registered outputs.
  // Priority: ignition > reprogram > door / timer events.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ARMED;
      interval_q   <= SEL_ARM;
      enable_siren <= 1'b0;
      alarm_source <= '0;
    end else if (ignition) begin
      state        <= DISARMED;
      interval_q   <= SEL_ARM;
      enable_siren <= 1'b0;
      if (state == TRIGGERED) begin
        alarm_source <= '0;
      end
    end else if (reprogram) begin
      state        <= ARMED;
      interval_q   <= SEL_ARM;
      enable_siren <= 1'b0;
      alarm_source <= '0;
    end else begin
      if (load) begin
        interval_q <= load_sel;
      end
      case (state)
        ARMED: begin
          if (door_any) begin
            state        <= TRIGGERED;
            alarm_source <= door;
          end
        end
        TRIGGERED: begin
          alarm_source <= alarm_source | door;
          if (expired) begin
            state        <= ALARM;
            enable_siren <= 1'b1;
          end
        end
        ALARM: begin
          alarm_source <= alarm_source | door;
          // alarm_source is kept on re-arm so the owner can see what happened.
          if (!door_any && expired) begin
            state        <= ARMED;
            interval_q   <= SEL_ARM;
            enable_siren <= 1'b0;
          end
        end
        DISARMED: begin
          if (door[0]) begin
            state <= WAIT_CLOSE;
          end
        end
        WAIT_CLOSE: begin
          if (!door_any) begin
            state <= ARM_DELAY;
          end
        end
        ARM_DELAY: begin
          if (door_any) begin
            state <= WAIT_CLOSE;
          end else if (expired) begin
            state <= ARMED;
          end
        end
        default: begin
          state <= ARMED;
        end
      endcase
    end
  end

  assign status   = status_of(state);
  assign interval = interval_q;

  // ---------------------------------------------------------------------------
  // Fuel-pump interlock, independent of the FSM: enabled by ignition + hidden
  // switch + brake together, held until the ignition drops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fuel_pump_power <= 1'b0;
    end else if (!ignition) begin
      fuel_pump_power <= 1'b0;
    end else if (hidden_sw && brake) begin
      fuel_pump_power <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fsm_antifurto_multizone.sv
// -----------------------------------------------------------------------------
// tb_fsm_antifurto_multizone
// Scenario-driven bench: each test pushes the expected output snapshot into a
// queue as it drives stimulus, then pops and compares it once the DUT has
// reacted. Inputs change 1 time unit after the rising edge and outputs are
// sampled at the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_fsm_antifurto_multizone;

  localparam int ND = 4;
  localparam int TW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          one_hz_enable;
  logic          ignition;
  logic [ND-1:0] door;
  logic          reprogram;
  logic [1:0]    time_param_sel;
  logic [TW-1:0] time_value;
  logic          hidden_sw;
  logic          brake;
  logic [1:0]    status;
  logic [1:0]    interval;
  logic          enable_siren;
  logic          fuel_pump_power;
  logic [TW-1:0] timer_value;
  logic [ND-1:0] alarm_source;

  fsm_antifurto_multizone #(
    .NUM_DOORS (ND),
    .TW        (TW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .one_hz_enable   (one_hz_enable),
    .ignition        (ignition),
    .door            (door),
    .reprogram       (reprogram),
    .time_param_sel  (time_param_sel),
    .time_value      (time_value),
    .hidden_sw       (hidden_sw),
    .brake           (brake),
    .status          (status),
    .interval        (interval),
    .enable_siren    (enable_siren),
    .fuel_pump_power (fuel_pump_power),
    .timer_value     (timer_value),
    .alarm_source    (alarm_source)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]    st;
    logic [1:0]    iv;
    logic          sir;
    logic          fp;
    logic [TW-1:0] tv;
    logic [ND-1:0] src;
  } obs_t;

  obs_t  exp_q[$];
  string nm_q[$];
  obs_t  got;
  obs_t  e;
  string nm;
  int    n_cmp = 0;
  int    n_mis = 0;

  function automatic obs_t snap();
    obs_t o;
    o.st  = status;
    o.iv  = interval;
    o.sir = enable_siren;
    o.fp  = fuel_pump_power;
    o.tv  = timer_value;
    o.src = alarm_source;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("status=%b interval=%b siren=%b pump=%b timer=%0d src=%b",
                     o.st, o.iv, o.sir, o.fp, o.tv, o.src);
  endfunction

  task automatic expect_obs(input string name, input logic [1:0] st, input logic [1:0] iv,
                            input logic sir, input logic fp, input logic [TW-1:0] tv,
                            input logic [ND-1:0] src);
    obs_t o;
    o.st = st; o.iv = iv; o.sir = sir; o.fp = fp; o.tv = tv; o.src = src;
    exp_q.push_back(o);
    nm_q.push_back(name);
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    one_hz_enable = 1'b1;
    cycle();
    one_hz_enable = 1'b0;
  endtask

  task automatic do_reset();
    one_hz_enable  = 1'b0;
    ignition       = 1'b0;
    door           = '0;
    reprogram      = 1'b0;
    time_param_sel = 2'b00;
    time_value     = '0;
    hidden_sw      = 1'b0;
    brake          = 1'b0;
    reset          = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    expect_obs("reset_state", 2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 4'b0000);
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
  endtask

  task automatic test_passenger_trigger();
    do_reset();
    door = 4'b0100;
    expect_obs("pass_trigger", 2'b01, 2'b10, 1'b0, 1'b0, 4'd15, 4'b0100);
    cycle();
    door = '0;
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    expect_obs("pass_count_zero", 2'b01, 2'b10, 1'b0, 1'b0, 4'd0, 4'b0100);
    repeat (15) tick();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    expect_obs("pass_alarm", 2'b10, 2'b11, 1'b1, 1'b0, 4'd10, 4'b0100);
    cycle();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
  endtask

  task automatic test_driver_wins_disarm();
    do_reset();
    door = 4'b0011;
    expect_obs("driver_wins", 2'b01, 2'b01, 1'b0, 1'b0, 4'd8, 4'b0011);
    cycle();
    door = '0;
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    repeat (5) tick();
    ignition = 1'b1;
    expect_obs("driver_disarm", 2'b11, 2'b00, 1'b0, 1'b0, 4'd3, 4'b0000);
    cycle();
    ignition = 1'b0;
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
  endtask

  task automatic test_alarm_hold();
    do_reset();
    door = 4'b0100;
    cycle();
    repeat (15) tick();
    cycle();
    expect_obs("alarm_hold_open", 2'b10, 2'b11, 1'b1, 1'b0, 4'd10, 4'b0100);
    repeat (20) tick();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    door = '0;
    expect_obs("alarm_hold_zero", 2'b10, 2'b11, 1'b1, 1'b0, 4'd0, 4'b0100);
    repeat (10) tick();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    expect_obs("alarm_rearm", 2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 4'b0100);
    cycle();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
  endtask

  task automatic test_rearm();
    do_reset();
    ignition = 1'b1;
    cycle();
    ignition = 1'b0;
    door = 4'b0001;
    cycle();
    door = '0;
    expect_obs("rearm_delay", 2'b11, 2'b00, 1'b0, 1'b0, 4'd6, 4'b0000);
    cycle();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    repeat (3) tick();
    door = 4'b0010;
    expect_obs("rearm_reopen", 2'b11, 2'b00, 1'b0, 1'b0, 4'd3, 4'b0000);
    cycle();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    door = '0;
    expect_obs("rearm_reload", 2'b11, 2'b00, 1'b0, 1'b0, 4'd6, 4'b0000);
    cycle();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    repeat (6) tick();
    expect_obs("rearm_armed", 2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 4'b0000);
    cycle();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
  endtask

  task automatic test_reprogram();
    do_reset();
    reprogram = 1'b1; time_param_sel = 2'b01; time_value = 4'd0;
    cycle();
    reprogram = 1'b0;
    door = 4'b0001;
    expect_obs("reprog_driver_min", 2'b01, 2'b01, 1'b0, 1'b0, 4'd1, 4'b0001);
    cycle();
    door = '0;
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    tick();
    expect_obs("reprog_alarm", 2'b10, 2'b11, 1'b1, 1'b0, 4'd10, 4'b0001);
    cycle();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    reprogram = 1'b1; time_param_sel = 2'b11; time_value = 4'd3;
    expect_obs("reprog_abort_alarm", 2'b00, 2'b00, 1'b0, 1'b0, 4'd10, 4'b0000);
    cycle();
    reprogram = 1'b0;
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    door = 4'b0001;
    cycle();
    door = '0;
    tick();
    expect_obs("reprog_new_alarm", 2'b10, 2'b11, 1'b1, 1'b0, 4'd3, 4'b0001);
    cycle();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
  endtask

  task automatic test_reprogram_ignition();
    do_reset();
    ignition = 1'b1;
    reprogram = 1'b1; time_param_sel = 2'b00; time_value = 4'd2;
    expect_obs("reprog_ign_disarmed", 2'b11, 2'b00, 1'b0, 1'b0, 4'd0, 4'b0000);
    cycle();
    reprogram = 1'b0;
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    ignition = 1'b0;
    door = 4'b0001;
    cycle();
    door = '0;
    expect_obs("reprog_ign_arm_delay", 2'b11, 2'b00, 1'b0, 1'b0, 4'd2, 4'b0000);
    cycle();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
  endtask

  task automatic test_fuel_pump();
    do_reset();
    ignition = 1'b1; brake = 1'b1; hidden_sw = 1'b0;
    expect_obs("fuel_no_hidden", 2'b11, 2'b00, 1'b0, 1'b0, 4'd0, 4'b0000);
    cycle();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    hidden_sw = 1'b1;
    expect_obs("fuel_enable", 2'b11, 2'b00, 1'b0, 1'b1, 4'd0, 4'b0000);
    cycle();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    brake = 1'b0; hidden_sw = 1'b0;
    expect_obs("fuel_hold", 2'b11, 2'b00, 1'b0, 1'b1, 4'd0, 4'b0000);
    cycle();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    ignition = 1'b0;
    expect_obs("fuel_ignition_off", 2'b11, 2'b00, 1'b0, 1'b0, 4'd0, 4'b0000);
    cycle();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    reprogram = 1'b1; time_param_sel = 2'b01; time_value = 4'd1;
    cycle();
    reprogram = 1'b0;
    door = 4'b0001;
    cycle();
    door = '0;
    tick();
    expect_obs("async_pre_alarm", 2'b10, 2'b11, 1'b1, 1'b0, 4'd10, 4'b0001);
    cycle();
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    expect_obs("async_reset_outputs", 2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 4'b0000);
    #2 reset = 1'b0;
    #1;
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
    #1 reset = 1'b1;
    door = 4'b0001;
    expect_obs("async_default_params", 2'b01, 2'b01, 1'b0, 1'b0, 4'd8, 4'b0001);
    cycle();
    door = '0;
    got = snap(); e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
    if (got !== e) begin n_mis++; $display("FAIL %s: got %s required %s", nm, fmt(got), fmt(e)); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_passenger_trigger();
    test_driver_wins_disarm();
    test_alarm_hold();
    test_rearm();
    test_reprogram();
    test_reprogram_ignition();
    test_fuel_pump();
    test_async_reset();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/fsm_antifurto_multizone.md
Name: fsm_antifurto_multizone

Overview:
Parametrised anti-theft controller for NUM_DOORS door channels, with the countdown timer, time-parameter bank and fuel-pump interlock integrated.
- Door 0 is the driver door; doors 1..NUM_DOORS-1 are passenger doors.
- Drives siren enable, status and fuel-pump power; sits between door/ignition sensor synchronisers and the siren generator.
- Adds over the previous single-driver/passenger FSM: N doors, programmable delays, door-source latching, alarm re-arm after doors close, and the fuel-pump cut.

Parameters:
NUM_DOORS, 4, number of door inputs (>=2)
TW, 4, width of time parameters and counter (seconds)
T_ARM_DEF, 6, default arm delay
T_DRIVER_DEF, 8, default driver-door entry delay
T_PASS_DEF, 15, default passenger-door entry delay
T_ALARM_DEF, 10, default siren hold after all doors close

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
one_hz_enable  in  1  single-cycle 1 Hz tick
ignition  in  1  ignition on
door  in  NUM_DOORS  1 = door open
reprogram  in  1  single-cycle pulse: store time_value into the selected parameter
time_param_sel  in  2  00 ARM, 01 DRIVER, 10 PASS, 11 ALARM
time_value  in  TW  new parameter value
hidden_sw  in  1  hidden switch
brake  in  1  brake pedal
status  out  2  00 armed, 01 triggered, 10 alarm, 11 disarmed
interval  out  2  parameter currently being timed (same code as time_param_sel)
enable_siren  out  1  siren on
fuel_pump_power  out  1  fuel pump enabled
timer_value  out  TW  remaining seconds
alarm_source  out  NUM_DOORS  doors that triggered or were opened during TRIGGERED/ALARM

Behaviour:
- Reset (reset=0, async) sets:
  - state ARMED
  - parameters to their defaults
  - counter 0, enable_siren 0, fuel_pump_power 0, alarm_source 0, interval 00
- All outputs are registered or decoded from registered state; no input-to-output combinational path.
- Timer:
  - Loads the selected parameter on state entry.
  - Decrements on one_hz_enable while counter > 0.
  - expired = (counter == 0), excluding the load cycle.
- States:
  - ARMED (status 00):
    - ignition -> DISARMED.
    - Else any door high -> TRIGGERED; latch alarm_source = door.
    - door[0] high loads T_DRIVER (interval 01), else loads T_PASS (interval 10).
    - Driver wins when driver and passenger doors open in the same cycle.
  - TRIGGERED (01):
    - ignition -> DISARMED; clear alarm_source.
    - expired -> ALARM, load T_ALARM.
    - alarm_source |= door every cycle.
  - ALARM (10):
    - enable_siren = 1.
    - While any door is open, counter reloads T_ALARM every cycle.
    - With all doors closed, counts down; expired -> ARMED, siren 0; alarm_source is kept until the next trigger.
    - ignition -> DISARMED; siren 0 the next cycle.
  - DISARMED (status 11): ignition 0 and door[0] high -> WAIT_CLOSE.
  - WAIT_CLOSE (status 11):
    - ignition -> DISARMED.
    - All doors closed -> ARM_DELAY, load T_ARM (interval 00).
  - ARM_DELAY (status 11):
    - ignition -> DISARMED.
    - Any door opens -> WAIT_CLOSE.
    - expired -> ARMED.
- Priority in every state: ignition > reprogram > door/timer events.
- reprogram:
  - Writes the selected parameter; time_value 0 is stored as 1.
  - If ignition is 0, also forces ARMED, siren 0, alarm_source 0.
  - If ignition is 1, stays DISARMED.
- A reprogram write takes effect from the next load; an in-flight countdown is not altered.
- ARMED is level-sensitive: entering ARMED with a door open triggers on the following cycle.
- interval is 00 in ARMED, DISARMED and WAIT_CLOSE.
- Fuel pump, independent of the FSM:
  - Set when ignition & hidden_sw & brake are all high in the same cycle.
  - Cleared when ignition = 0.
  - Reset clears it.

Decomposition:
- Package antifurto_pkg: state enum (ARMED, TRIGGERED, ALARM, DISARMED, WAIT_CLOSE, ARM_DELAY), interval/param-select codes, status codes, default time constants.
- Sub-module antifurto_timer (TW):
  - Ports: load, load_value, one_hz_enable, counter, expired.
  - The parameter bank and FSM stay in the top.

Test Plan:
- Reset then door=4'b0100 -> next cycle TRIGGERED, interval 10, timer_value 15; after 15 ticks status 10, enable_siren 1, alarm_source 4'b0100.
- ARMED, door=4'b0011 same cycle -> interval 01, timer 8; ignition at tick 5 -> DISARMED, siren 0, alarm_source 0.
- ALARM with door[2] held open for 20 ticks -> timer_value stays 10; close it -> 10 ticks later ARMED, enable_siren 0.
- DISARMED, ignition 0, door[0] 1 then 0 -> ARM_DELAY with timer 6; reopen door[1] at tick 3 -> WAIT_CLOSE; close -> timer reloads 6; 6 ticks -> ARMED.
- reprogram sel=01, value=0 -> stored 1; next driver trigger expires after 1 tick. Reprogram sel=11 value=3 during ALARM -> ARMED, siren 0 immediately.
- Fuel pump:
  - ignition=1, brake=1, hidden_sw=0 -> fuel_pump_power 0.
  - Assert hidden_sw -> 1, holds after releasing brake.
  - ignition=0 -> 0.
  - Async reset mid-ALARM -> all outputs at reset values with no clock edge.
